// File: rtl/regflgwei_replay.sv
// Purpose : circular flag-word register file; WR_NUM words in per beat, one word out per pop,
//           and each block of blk_len words is replayed pass times before its entries are freed.
// Latency : a word written at cycle t can be popped at t+1 (no write-through); block_done is registered.
// Backpr. : datain_rdy drops once a whole beat no longer fits; dataout_val drops when the cursor
//           reaches unwritten entries (partial blocks stall word by word).
// Ports   : clk/rst (async, active high); clear + cfg_blk_len/cfg_pass load a new block config;
//           datain_val/datain_rdy/datain write beat; dataout_val/dataout_rdy/dataout read word;
//           block_done pulses after the final pass of a block; fill_cnt = occupied entries.
module regflgwei_replay #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int WR_NUM     = 2,
  parameter int PASS_WIDTH = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic [ADDR_WIDTH:0]          cfg_blk_len,
  input  logic [PASS_WIDTH-1:0]        cfg_pass,
  input  logic                         datain_val,
  output logic                         datain_rdy,
  input  logic [WR_NUM*DATA_WIDTH-1:0] datain,
  output logic                         dataout_val,
  input  logic                         dataout_rdy,
  output logic [DATA_WIDTH-1:0]        dataout,
  output logic                         block_done,
  output logic [ADDR_WIDTH:0]          fill_cnt
);

  localparam logic [ADDR_WIDTH:0]   FULL_TH = (ADDR_WIDTH+1)'(DEPTH - WR_NUM);
  localparam logic [ADDR_WIDTH:0]   WR_INC  = (ADDR_WIDTH+1)'(WR_NUM);
  localparam logic [ADDR_WIDTH:0]   ONE_A   = (ADDR_WIDTH+1)'(1);
  localparam logic [PASS_WIDTH-1:0] ONE_P   = PASS_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_base;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic [ADDR_WIDTH:0]   blk_len_q;
  logic [PASS_WIDTH-1:0] pass_cnt;
  logic [PASS_WIDTH-1:0] pass_q;
  logic [ADDR_WIDTH:0]   fill_next;
  logic                  wr_fire;
  logic                  pop;
  logic                  last_word;
  logic                  last_pass;
  logic                  final_pop;

  // Both handshakes are masked by clear, so a clear cycle never writes or pops.
  assign datain_rdy  = !clear && (fill_cnt <= FULL_TH);
  assign dataout_val = !clear && (word_cnt < fill_cnt) && (fill_cnt != '0);

  // word_cnt stays below blk_len_q <= DEPTH, so its low bits are a valid offset.
  assign rd_ptr  = rd_base + word_cnt[ADDR_WIDTH-1:0];
  assign dataout = dataout_val ? mem[rd_ptr] : '0;

  assign wr_fire   = datain_val && datain_rdy;
  assign pop       = dataout_val && dataout_rdy;
  assign last_word = (word_cnt == blk_len_q - ONE_A);
  assign last_pass = (pass_cnt == pass_q - ONE_P);
  assign final_pop = pop && last_word && last_pass;

  // Write and block release in one expression so a coincident beat and final pop both land.
  assign fill_next = fill_cnt + (wr_fire ? WR_INC : '0) - (final_pop ? blk_len_q : '0);

  // Storage has no reset; contents are only observed behind dataout_val.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < WR_NUM; i++) begin
        mem[wr_ptr + ADDR_WIDTH'(i)] <= datain[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_base    <= '0;
      word_cnt   <= '0;
      pass_cnt   <= '0;
      fill_cnt   <= '0;
      blk_len_q  <= ONE_A;
      pass_q     <= ONE_P;
      block_done <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_base    <= '0;
      word_cnt   <= '0;
      pass_cnt   <= '0;
      fill_cnt   <= '0;
      // Zero-length blocks or zero passes would never release entries; clamp to 1.
      blk_len_q  <= (cfg_blk_len == '0) ? ONE_A : cfg_blk_len;
      pass_q     <= (cfg_pass == '0) ? ONE_P : cfg_pass;
      block_done <= 1'b0;
    end else begin
      fill_cnt   <= fill_next;
      block_done <= final_pop;
      if (wr_fire) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(WR_NUM);
      end
      if (pop) begin
        if (!last_word) begin
          word_cnt <= word_cnt + ONE_A;
        end else if (!last_pass) begin
          // Rewind to the start of the same block for another pass.
          word_cnt <= '0;
          pass_cnt <= pass_cnt + ONE_P;
        end else begin
          rd_base  <= rd_base + blk_len_q[ADDR_WIDTH-1:0];
          word_cnt <= '0;
          pass_cnt <= '0;
        end
      end
    end
  end

endmodule
